multiplier_scheduler: RTL and testbench
=======================================

MULTIPLIER_SCHEDULER -- requirements
Module: multiplier_scheduler

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning the operand and result width.
REQ-002 The block SHALL have parameter TAG_WIDTH, default 5, meaning the width of the requester destination tag.
REQ-003 The block SHALL have parameter LATENCY, default 6, meaning the number of clock edges from the Multiplier sampling its operands to a valid result.
REQ-004 The block SHALL have port clock, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset_n, input, 1 bit, the reset; it is asynchronous and active-low.
REQ-006 The block SHALL have port flush, input, 1 bit, which kills all in-flight operations.
REQ-007 The block SHALL have, for each requester k in {0,1}: input reqk_valid (1), output reqk_ready (1), input reqk_a (WIDTH, multiplicand), input reqk_b (WIDTH, multiplier) and input reqk_tag (TAG_WIDTH).
REQ-008 The block SHALL have multiplier-side ports: output mul_start (1), output mul_multiplicand (WIDTH), output mul_multiplier (WIDTH), input mul_result (WIDTH) and input mul_overflow (1).
REQ-009 The block SHALL have response ports: output resp_valid (1), output resp_requester (1), output resp_tag (TAG_WIDTH), output resp_result (WIDTH) and output resp_overflow (1).
REQ-010 The block SHALL have port busy, output, 1 bit, high while any operation is in flight.

Function
REQ-011 Transfer SHALL occur on a rising edge where reqk_valid=1 and reqk_ready=1; at most one transfer SHALL occur per edge.
REQ-012 reqk_ready SHALL be combinational: high only for the requester granted this cycle, low for both while flush=1, and independent of the other requester's operands.
REQ-013 On transfer at edge E, mul_start SHALL be 1 and the mul_ operands SHALL hold the accepted operands for exactly the cycle following E; otherwise mul_start=0 and the operands hold their previous values.
REQ-014 A tracking pipeline of LATENCY+1 stages SHALL carry {valid, requester, tag} per issue, accept one new entry per cycle, and sustain back-to-back issue with no bubbles.
REQ-015 resp_valid SHALL be asserted in the single cycle following edge E+LATENCY+1 (7 edges after acceptance by default); in that cycle resp_requester and resp_tag SHALL equal the issuing values, and resp_result=mul_result, resp_overflow=mul_overflow.
REQ-016 Responses SHALL be returned in issue order and SHALL NOT be backpressured.
REQ-017 busy SHALL be the OR of all tracking-stage valid bits.
REQ-018 When flush=1 at an edge, all tracking valid bits SHALL clear, no transfer SHALL occur, and resp_valid SHALL be 0 in the following cycle even if a kill lands on its stage.
REQ-019 An operation accepted in the cycle after flush deasserts SHALL complete normally; stale Multiplier pipeline contents SHALL never raise resp_valid.
REQ-020 When resp_valid=0, resp_result, resp_tag and resp_overflow SHALL be don't-care, and the bench SHALL NOT check them.

Reset
REQ-021 While reset_n=0 the block SHALL clear all tracking valid bits and the arbitration pointer (to requester 0), and SHALL drive mul_start=0, mul_multiplicand=0, mul_multiplier=0, resp_valid=0, busy=0 and both reqk_ready=0.
REQ-022 Reset asserted mid-operation SHALL discard all in-flight operations; no response SHALL emerge for them after reset_n rises.
REQ-023 On the first edge after reset_n rises, a request SHALL be accepted normally.

Configuration
REQ-024 With macro MULTIPLIER_SCHEDULER_ROUND_ROBIN_EN defined, the grant SHALL alternate: after a transfer the pointer moves to the other requester, the pointed requester wins when both are valid, and a lone valid requester always wins.
REQ-025 Without MULTIPLIER_SCHEDULER_ROUND_ROBIN_EN, the arbitration SHALL be fixed priority with requester 0 always winning when both are valid, and the pointer logic SHALL be absent.

Verification
REQ-026 Single issue: req0 a=7, b=6, tag=3 accepted at edge E SHALL produce resp_valid only in the cycle after E+7, with resp_result=42, resp_requester=0, resp_tag=3 and resp_overflow=0.
REQ-027 Overflow: req1 a=0x10000, b=0x10000 SHALL produce resp_result=0 and resp_overflow=1.
REQ-028 Contention: both requesters held valid for 4 cycles SHALL be granted 0,1,0,1 with round robin and 0,0,0,0 without it, and responses SHALL arrive on 4 consecutive cycles in the same order.
REQ-029 Flush: 3 back-to-back issues followed by flush=1 for one cycle SHALL produce no responses, busy=0 after the flush edge, and both readies low during the flush cycle.
REQ-030 Reset mid-flight: reset_n pulsed low 2 cycles after an issue SHALL produce no response and busy=0; a new request with a=5, b=5 SHALL then return 25.

Source files
------------

// File: rtl/multiplier_scheduler.sv
// multiplier_scheduler
//   Arbitrates two requesters onto a single pipelined Multiplier (fixed
//   LATENCY) and returns each result to its issuing requester, in issue
//   order, with the requester's destination tag attached.
//
//   A tracking pipeline of LATENCY+1 stages follows every issue. Stage 0 is
//   the issue cycle itself, so its valid bit doubles as mul_start. The last
//   stage feeds the response register, which lines up with the Multiplier's
//   output LATENCY edges after it samples the operands.
//
//   Build option:
//     MULTIPLIER_SCHEDULER_ROUND_ROBIN_EN - alternating grant between the
//     two requesters. When it is undefined, requester 0 has fixed priority
//     and no pointer state exists.
module multiplier_scheduler #(
  parameter int WIDTH     = 32,
  parameter int TAG_WIDTH = 5,
  parameter int LATENCY   = 6
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 flush,

  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [WIDTH-1:0]     req0_a,
  input  logic [WIDTH-1:0]     req0_b,
  input  logic [TAG_WIDTH-1:0] req0_tag,

  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [WIDTH-1:0]     req1_a,
  input  logic [WIDTH-1:0]     req1_b,
  input  logic [TAG_WIDTH-1:0] req1_tag,

  output logic                 mul_start,
  output logic [WIDTH-1:0]     mul_multiplicand,
  output logic [WIDTH-1:0]     mul_multiplier,
  input  logic [WIDTH-1:0]     mul_result,
  input  logic                 mul_overflow,

  output logic                 resp_valid,
  output logic                 resp_requester,
  output logic [TAG_WIDTH-1:0] resp_tag,
  output logic [WIDTH-1:0]     resp_result,
  output logic                 resp_overflow,

  output logic                 busy
);

  localparam int STAGES = LATENCY + 1;

  logic                 grant0;
  logic                 grant1;
  logic                 fire;
  logic                 fireReq;

  logic [STAGES-1:0]    trackValid;
  logic [STAGES-1:0]    trackReq;
  logic [TAG_WIDTH-1:0] trackTag [STAGES];

  logic                 respValidQ;

`ifdef MULTIPLIER_SCHEDULER_ROUND_ROBIN_EN
  // Points at the requester that wins the next tie.
  logic rrPtr;

  // Grant: pointed requester wins a tie, a lone requester always wins.
  always_comb begin
    // NOTE: defaults first so every path assigns both grants and no latch is inferred.
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (req0_valid && req1_valid) begin
      grant0 = ~rrPtr;
      grant1 = rrPtr;
    end else begin
      grant0 = req0_valid;
      grant1 = req1_valid;
    end
  end

  // Pointer hands the next tie to whichever requester did not just transfer.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rrPtr <= 1'b0;
    end else if (fire) begin
      rrPtr <= ~fireReq;
    end
  end
`else
  // Fixed priority: requester 0 wins whenever it is valid.
  assign grant0 = req0_valid;
  assign grant1 = req1_valid & ~req0_valid;
`endif

  // Ready is withheld during flush and while reset is asserted.
  assign req0_ready = grant0 & ~flush & reset_n;
  assign req1_ready = grant1 & ~flush & reset_n;

  // At most one ready is high, so it identifies the transferring requester.
  assign fire    = req0_ready | req1_ready;
  assign fireReq = req1_ready;

  // Operand registers: load on transfer, otherwise hold.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
      mul_multiplicand <= '0;
      mul_multiplier   <= '0;
    end else if (fire) begin
      mul_multiplicand <= fireReq ? req1_a : req0_a;
      mul_multiplier   <= fireReq ? req1_b : req0_b;
    end
  end

  // Tracking valid bits: shift one stage per edge; flush kills every stage.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      trackValid <= '0;
    end else if (flush) begin
      trackValid <= '0;
    end else begin
      trackValid <= {trackValid[STAGES-2:0], fire};
    end
  end

  // Tracking payload: requester and tag travel alongside their valid bit.
  always_ff @(posedge clock) begin
    // NOTE: payload registers carry no reset; the valid bit alone decides whether a stage means anything.
    trackReq    <= {trackReq[STAGES-2:0], fireReq};
    trackTag[0] <= fireReq ? req1_tag : req0_tag;
    for (int i = 1; i < STAGES; i++) begin
      trackTag[i] <= trackTag[i-1];
    end
  end

  // Response valid: one edge past the last tracking stage, suppressed by flush.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      respValidQ <= 1'b0;
    end else begin
      respValidQ <= trackValid[STAGES-1] & ~flush;
    end
  end

  // Response payload registers, aligned with respValidQ.
  always_ff @(posedge clock) begin
    resp_requester <= trackReq[STAGES-1];
    resp_tag       <= trackTag[STAGES-1];
  end

  assign mul_start     = trackValid[0];
  assign busy          = |trackValid;
  assign resp_valid    = respValidQ;
  assign resp_result   = mul_result;
  assign resp_overflow = mul_overflow;

endmodule

// File: tb/tb_multiplier_scheduler.sv
// tb_multiplier_scheduler
//   Drives multiplier_scheduler against a behavioural LATENCY-edge
//   Multiplier. Each driven transfer pushes its expected response onto a
//   scoreboard queue together with the cycle it must appear in; a negedge
//   monitor pops and compares. Build with MULTIPLIER_SCHEDULER_ROUND_ROBIN_EN
//   defined to expect alternating grants instead of fixed priority.
module tb_multiplier_scheduler;

  localparam int WIDTH     = 32;
  localparam int TAG_WIDTH = 5;
  localparam int LATENCY   = 6;

  logic                 clock;
  logic                 reset_n;
  logic                 flush;
  logic                 req0_valid, req1_valid;
  logic                 req0_ready, req1_ready;
  logic [WIDTH-1:0]     req0_a, req0_b, req1_a, req1_b;
  logic [TAG_WIDTH-1:0] req0_tag, req1_tag;
  logic                 mul_start;
  logic [WIDTH-1:0]     mul_multiplicand, mul_multiplier;
  logic [WIDTH-1:0]     mul_result;
  logic                 mul_overflow;
  logic                 resp_valid, resp_requester;
  logic [TAG_WIDTH-1:0] resp_tag;
  logic [WIDTH-1:0]     resp_result;
  logic                 resp_overflow;
  logic                 busy;

  int passCount  = 0;
  int checkCount = 0;
  int cycleCount = 0;

`ifdef MULTIPLIER_SCHEDULER_ROUND_ROBIN_EN
  logic tbPtr = 1'b0;
`endif

  typedef struct {
    logic                 req;
    logic [TAG_WIDTH-1:0] tag;
    logic [WIDTH-1:0]     result;
    logic                 ovf;
    int                   due;
  } exp_t;

  exp_t expQ[$];
  exp_t monE;

  multiplier_scheduler #(
    .WIDTH(WIDTH), .TAG_WIDTH(TAG_WIDTH), .LATENCY(LATENCY)
  ) dut (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
    .req0_b(req0_b), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
    .req1_b(req1_b), .req1_tag(req1_tag),
    .mul_start(mul_start), .mul_multiplicand(mul_multiplicand),
    .mul_multiplier(mul_multiplier), .mul_result(mul_result),
    .mul_overflow(mul_overflow),
    .resp_valid(resp_valid), .resp_requester(resp_requester),
    .resp_tag(resp_tag), .resp_result(resp_result),
    .resp_overflow(resp_overflow), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cycleCount <= cycleCount + 1;

  // Behavioural Multiplier: samples operands every edge, result LATENCY edges later.
  logic [WIDTH:0] mulPipe [LATENCY+1];
  always @(posedge clock) begin
    logic [2*WIDTH-1:0] prod;
    prod = {{WIDTH{1'b0}}, mul_multiplicand} * {{WIDTH{1'b0}}, mul_multiplier};
    mulPipe[0] <= {|prod[2*WIDTH-1:WIDTH], prod[WIDTH-1:0]};
    for (int i = 1; i <= LATENCY; i++) mulPipe[i] <= mulPipe[i-1];
  end
  assign mul_result   = mulPipe[LATENCY][WIDTH-1:0];
  assign mul_overflow = mulPipe[LATENCY][WIDTH];

  // Scoreboard monitor: every response must match the queue head in content and cycle.
  always @(negedge clock) begin
    if (resp_valid === 1'b1) begin
      checkCount++;
      if (expQ.size() == 0) begin
        $display("FAIL resp_unexpected: resp_valid=1 tag=%0d at cycle %0d, required no response",
                 resp_tag, cycleCount);
      end else begin
        monE = expQ.pop_front();
        if (resp_requester !== monE.req || resp_tag !== monE.tag ||
            resp_result !== monE.result || resp_overflow !== monE.ovf ||
            cycleCount != monE.due)
          $display("FAIL resp: got req=%0d tag=%0d result=%0h ovf=%0d cycle=%0d, required req=%0d tag=%0d result=%0h ovf=%0d cycle=%0d",
                   resp_requester, resp_tag, resp_result, resp_overflow, cycleCount,
                   monE.req, monE.tag, monE.result, monE.ovf, monE.due);
        else
          passCount++;
      end
    end else if (expQ.size() > 0 && expQ[0].due <= cycleCount) begin
      checkCount++;
      monE = expQ.pop_front();
      $display("FAIL resp_missing: resp_valid=%b at cycle %0d, required 1 (tag=%0d)",
               resp_valid, cycleCount, monE.tag);
    end
  end

  // Presents one cycle of requests (releasing reset/flush), checks ready
  // against the arbitration model and queues the expected response.
  task automatic drive(input logic v0, input logic [WIDTH-1:0] a0, b0,
                       input logic [TAG_WIDTH-1:0] t0,
                       input logic v1, input logic [WIDTH-1:0] a1, b1,
                       input logic [TAG_WIDTH-1:0] t1, output int granted);
    logic e0, e1;
    logic [2*WIDTH-1:0] p;
    exp_t e;
    @(negedge clock);
    reset_n = 1'b1; flush = 1'b0;
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_tag = t0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_tag = t1;
    #1;
`ifdef MULTIPLIER_SCHEDULER_ROUND_ROBIN_EN
    if (v0 && v1) begin e0 = ~tbPtr; e1 = tbPtr; end
    else begin e0 = v0; e1 = v1; end
`else
    e0 = v0; e1 = v1 & ~v0;
`endif
    checkCount++;
    if (req0_ready !== e0 || req1_ready !== e1)
      $display("FAIL ready: got req0_ready=%b req1_ready=%b, required %b %b",
               req0_ready, req1_ready, e0, e1);
    else
      passCount++;
    granted = e0 ? 0 : (e1 ? 1 : -1);
    if (granted >= 0) begin
      p = e1 ? {{WIDTH{1'b0}}, a1} * {{WIDTH{1'b0}}, b1}
             : {{WIDTH{1'b0}}, a0} * {{WIDTH{1'b0}}, b0};
      e.req    = e1;
      e.tag    = e1 ? t1 : t0;
      e.result = p[WIDTH-1:0];
      e.ovf    = |p[2*WIDTH-1:WIDTH];
      e.due    = cycleCount + LATENCY + 2;
      expQ.push_back(e);
`ifdef MULTIPLIER_SCHEDULER_ROUND_ROBIN_EN
      tbPtr = e0;
`endif
    end
  endtask

  // Idles the requesters until the scoreboard drains, within a cycle budget.
  task automatic drain(input string name);
    int n = 0;
    @(negedge clock);
    req0_valid = 1'b0; req1_valid = 1'b0;
    while (expQ.size() > 0 && n < 60) begin
      @(negedge clock);
      n++;
    end
    checkCount++;
    if (expQ.size() != 0)
      $display("FAIL %s_drain: %0d responses outstanding after timeout, required 0", name, expQ.size());
    else
      passCount++;
  endtask

  // Holds reset for one edge with no checks; the next drive releases it.
  task automatic apply_reset();
    @(negedge clock);
    reset_n = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    expQ.delete();
`ifdef MULTIPLIER_SCHEDULER_ROUND_ROBIN_EN
    tbPtr = 1'b0;
`endif
  endtask

  // Checks that resp_valid stays low until the queue head falls due.
  task automatic quiet_until_due(input string name);
    int due;
    due = (expQ.size() > 0) ? expQ[0].due : cycleCount + 10;
    while (cycleCount + 1 < due) begin
      @(negedge clock);
      req0_valid = 1'b0; req1_valid = 1'b0;
      #1;
      checkCount++;
      if (resp_valid !== 1'b0)
        $display("FAIL %s_quiet: resp_valid=%b at cycle %0d, required 0", name, resp_valid, cycleCount);
      else
        passCount++;
    end
  endtask

  task automatic test_reset();
    @(negedge clock);
    @(negedge clock);
    #1;
    checkCount++; if (mul_start !== 1'b0) $display("FAIL rst_mul_start: got %b required 0", mul_start); else passCount++;
    checkCount++; if (mul_multiplicand !== '0) $display("FAIL rst_multiplicand: got %0h required 0", mul_multiplicand); else passCount++;
    checkCount++; if (mul_multiplier !== '0) $display("FAIL rst_multiplier: got %0h required 0", mul_multiplier); else passCount++;
    checkCount++; if (resp_valid !== 1'b0) $display("FAIL rst_resp_valid: got %b required 0", resp_valid); else passCount++;
    checkCount++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b required 0", busy); else passCount++;
    checkCount++; if (req0_ready !== 1'b0) $display("FAIL rst_req0_ready: got %b required 0", req0_ready); else passCount++;
    checkCount++; if (req1_ready !== 1'b0) $display("FAIL rst_req1_ready: got %b required 0", req1_ready); else passCount++;
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_single();
    int g;
    drive(1'b1, 7, 6, 3, 1'b0, 0, 0, 0, g);
    @(negedge clock);
    req0_valid = 1'b0;
    #1;
    checkCount++; if (mul_start !== 1'b1) $display("FAIL single_start: got %b required 1", mul_start); else passCount++;
    checkCount++; if (mul_multiplicand !== 7 || mul_multiplier !== 6)
      $display("FAIL single_operands: got %0d*%0d required 7*6", mul_multiplicand, mul_multiplier); else passCount++;
    checkCount++; if (busy !== 1'b1) $display("FAIL single_busy: got %b required 1", busy); else passCount++;
    @(negedge clock);
    #1;
    checkCount++; if (mul_start !== 1'b0) $display("FAIL single_start_drop: got %b required 0", mul_start); else passCount++;
    checkCount++; if (mul_multiplicand !== 7 || mul_multiplier !== 6)
      $display("FAIL single_hold: got %0d*%0d required 7*6", mul_multiplicand, mul_multiplier); else passCount++;
    drain("single");
  endtask

  task automatic test_overflow();
    int g;
    drive(1'b0, 0, 0, 0, 1'b1, 32'h0001_0000, 32'h0001_0000, 9, g);
    drain("overflow");
  endtask

  task automatic test_contention();
    int g;
    int seen [4];
    int want [4];
    logic [WIDTH-1:0]     a0 = 3, a1 = 100;
    logic [TAG_WIDTH-1:0] t0 = 10, t1 = 20;
`ifdef MULTIPLIER_SCHEDULER_ROUND_ROBIN_EN
    want = '{0, 1, 0, 1};
`else
    want = '{0, 0, 0, 0};
`endif
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, a0, 5, t0, 1'b1, a1, 7, t1, g);
      seen[i] = req0_ready ? 0 : (req1_ready ? 1 : -1);
      if (g == 0) begin a0 = a0 + 1; t0 = t0 + 1; end
      if (g == 1) begin a1 = a1 + 1; t1 = t1 + 1; end
    end
    for (int i = 0; i < 4; i++) begin
      checkCount++;
      if (seen[i] != want[i])
        $display("FAIL contention_grant%0d: got requester %0d required %0d", i, seen[i], want[i]);
      else
        passCount++;
    end
    drain("contention");
  endtask

  task automatic test_flush();
    int g;
    for (int i = 0; i < 3; i++) drive(1'b1, 10 + i, 3, TAG_WIDTH'(i + 1), 1'b0, 0, 0, 0, g);
    @(negedge clock);
    flush = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    checkCount++; if (req0_ready !== 1'b0) $display("FAIL flush_req0_ready: got %b required 0", req0_ready); else passCount++;
    checkCount++; if (req1_ready !== 1'b0) $display("FAIL flush_req1_ready: got %b required 0", req1_ready); else passCount++;
    expQ.delete();
    drive(1'b0, 0, 0, 0, 1'b1, 3, 4, 17, g);
    checkCount++; if (busy !== 1'b0) $display("FAIL flush_busy: got %b required 0", busy); else passCount++;
    checkCount++; if (mul_start !== 1'b0) $display("FAIL flush_start: got %b required 0", mul_start); else passCount++;
    quiet_until_due("flush");
    drain("flush");
  endtask

  task automatic test_reset_midflight();
    int g;
    drive(1'b1, 9, 9, 7, 1'b0, 0, 0, 0, g);
    @(negedge clock);
    req0_valid = 1'b0;
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    expQ.delete();
`ifdef MULTIPLIER_SCHEDULER_ROUND_ROBIN_EN
    tbPtr = 1'b0;
`endif
    checkCount++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b required 0", busy); else passCount++;
    checkCount++; if (mul_start !== 1'b0) $display("FAIL midrst_start: got %b required 0", mul_start); else passCount++;
    drive(1'b1, 5, 5, 4, 1'b0, 0, 0, 0, g);
    checkCount++; if (busy !== 1'b0) $display("FAIL midrst_busy_release: got %b required 0", busy); else passCount++;
    quiet_until_due("midrst");
    drain("midrst");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0; flush = 1'b0;
    req0_valid = 1'b1; req0_a = '0; req0_b = '0; req0_tag = '0;
    req1_valid = 1'b1; req1_a = '0; req1_b = '0; req1_tag = '0;
    test_reset();
    test_single();
    test_overflow();
    test_contention();
    test_flush();
    test_reset_midflight();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
